// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback arbiter
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - MDU result FIFO with per-entry kill-by-destination compare
module wb_buffer
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  push_kill,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0]     head_data,
  output logic                  head_kill,
  output logic [CNT_W-1:0]      count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic                  kill;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Kill marks stale slots too; harmless since they are overwritten on push
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && mem[i].rd == kill_rd) mem[i].kill <= 1'b1;
    end
    if (push) mem[wr_ptr] <= '{rd: push_rd, data: push_data, kill: push_kill};
  end

  assign head_rd   = mem[rd_ptr].rd;
  assign head_data = mem[rd_ptr].data;
  assign head_kill = mem[rd_ptr].kill;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - arbitrates the register-file write port between pipeline and MDU
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pipe_we_i,
  input  logic [REG_ADDR_W-1:0] pipe_rd_i,
  input  logic [DATA_W-1:0]     pipe_data_i,
  input  logic                  mdu_valid_i,
  input  logic [REG_ADDR_W-1:0] mdu_rd_i,
  input  logic [DATA_W-1:0]     mdu_data_i,
  output logic                  mdu_ready_o,
  output logic                  stall_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic [$clog2(DEPTH):0] buf_cnt_o
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wb_state_t             state, state_n;
  logic [WAIT_W-1:0]     wait_cnt, wait_n;
  logic                  we_n;
  logic [REG_ADDR_W-1:0] rd_n;
  logic [DATA_W-1:0]     data_n;

  logic                  push, push_kill, pop, kill_en;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;
  logic                  head_kill;
  logic [CNT_W-1:0]      count;

  logic pipe_req, mdu_xfer, mdu_live, buf_empty;

  wb_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (push),
    .push_rd   (mdu_rd_i),
    .push_data (mdu_data_i),
    .push_kill (push_kill),
    .pop       (pop),
    .kill_en   (kill_en),
    .kill_rd   (pipe_rd_i),
    .head_rd   (head_rd),
    .head_data (head_data),
    .head_kill (head_kill),
    .count     (count)
  );

  assign mdu_ready_o = (count < CNT_W'(DEPTH));
  assign buf_cnt_o   = count;
  assign stall_o     = (state == DRAIN);
  assign pipe_req    = pipe_we_i && (pipe_rd_i != '0);
  assign mdu_xfer    = mdu_valid_i && mdu_ready_o;
  assign mdu_live    = mdu_xfer && (mdu_rd_i != '0);
  assign buf_empty   = (count == '0);

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    we_n      = 1'b0;
    rd_n      = '0;
    data_n    = '0;
    push      = 1'b0;
    push_kill = 1'b0;
    pop       = 1'b0;
    kill_en   = 1'b0;
    if (state == DRAIN) begin
      pop     = 1'b1;
      we_n    = !head_kill;
      rd_n    = head_kill ? '0 : head_rd;
      data_n  = head_kill ? '0 : head_data;
      wait_n  = '0;
      push    = mdu_live;
      state_n = RUN;
    end else if (pipe_req) begin
      we_n      = 1'b1;
      rd_n      = pipe_rd_i;
      data_n    = pipe_data_i;
      kill_en   = 1'b1;
      push      = mdu_live;
      push_kill = (mdu_rd_i == pipe_rd_i);
      if (!buf_empty) wait_n = wait_cnt + WAIT_W'(1);
      if (!buf_empty && wait_n == WAIT_W'(MAX_WAIT)) state_n = DRAIN;
    end else if (!buf_empty) begin
      pop    = 1'b1;
      we_n   = !head_kill;
      rd_n   = head_kill ? '0 : head_rd;
      data_n = head_kill ? '0 : head_data;
      wait_n = '0;
      push   = mdu_live;
    end else if (mdu_live) begin
      we_n   = 1'b1;
      rd_n   = mdu_rd_i;
      data_n = mdu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= RUN;
      wait_cnt   <= '0;
      rf_we_o    <= 1'b0;
      rf_rd_o    <= '0;
      rf_wdata_o <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      rf_we_o    <= we_n;
      rf_rd_o    <= rd_n;
      rf_wdata_o <= data_n;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready, stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  buf_cnt;

  wb_arbiter #(.DATA_W(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pipe_we_i   (pipe_we),
    .pipe_rd_i   (pipe_rd),
    .pipe_data_i (pipe_data),
    .mdu_valid_i (mdu_valid),
    .mdu_rd_i    (mdu_rd),
    .mdu_data_i  (mdu_data),
    .mdu_ready_o (mdu_ready),
    .stall_o     (stall),
    .rf_we_o     (rf_we),
    .rf_rd_o     (rf_rd),
    .rf_wdata_o  (rf_wdata),
    .buf_cnt_o   (buf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  int          starve;
  bit          m_drain;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] dut_rf [32];

  bit          exp_we, exp_stall, exp_ready;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  int          exp_cnt;
  logic        pre_stall, pre_ready;

  // Behavioural model: a queue of pending results plus a denied-cycle tally
  task automatic model_step(input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                            input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit   xfer, live, had;
    ent_t e;
    exp_ready = (mq.size() < DEPTH);
    exp_stall = m_drain;
    xfer = mv && exp_ready;
    live = xfer && (mrd != 0);
    exp_we = 0; exp_rd = 0; exp_data = 0;
    if (m_drain) begin
      e = mq.pop_front();
      if (!e.kill) begin exp_we = 1; exp_rd = e.rd; exp_data = e.data; end
      starve = 0; m_drain = 0;
      if (live) mq.push_back('{mrd, md, 1'b0});
    end else if (pw && prd != 0) begin
      exp_we = 1; exp_rd = prd; exp_data = pd;
      had = (mq.size() > 0);
      foreach (mq[i]) if (mq[i].rd == prd) mq[i].kill = 1;
      if (live) mq.push_back('{mrd, md, (mrd == prd)});
      if (had) starve++;
      if (had && starve == MAX_WAIT) m_drain = 1;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (!e.kill) begin exp_we = 1; exp_rd = e.rd; exp_data = e.data; end
      starve = 0;
      if (live) mq.push_back('{mrd, md, 1'b0});
    end else if (live) begin
      exp_we = 1; exp_rd = mrd; exp_data = md;
    end
    exp_cnt = mq.size();
  endtask

  task automatic cycle(input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    pre_stall = stall; pre_ready = mdu_ready;
    model_step(pw, prd, pd, mv, mrd, md);
    @(posedge clk); #1;
    if (rf_we) dut_rf[rf_rd] = rf_wdata;
  endtask

  task automatic do_reset();
    pipe_we = 0; mdu_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete(); starve = 0; m_drain = 0;
    foreach (dut_rf[i]) dut_rf[i] = 0;
  endtask

  task automatic test_reset();
    pipe_we = 1; pipe_rd = 5'd3; pipe_data = 32'hDEAD_0003;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rf_we !== 1'b0)   begin n_err++; $display("FAIL reset_we got %0b want 0", rf_we); end
    n_vec++; if (rf_rd !== 5'd0)   begin n_err++; $display("FAIL reset_rd got %0d want 0", rf_rd); end
    n_vec++; if (rf_wdata !== 0)   begin n_err++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    n_vec++; if (buf_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", buf_cnt); end
    n_vec++; if (stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", mdu_ready); end
    rst_n = 1;
    mq.delete(); starve = 0; m_drain = 0;
    cycle(1, 5'd3, 32'hDEAD_0003, 0, 0, 0);
    n_vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hDEAD_0003)
      begin n_err++; $display("FAIL reset_first_write got we=%0b rd=%0d d=%h want 1/3/dead0003", rf_we, rf_rd, rf_wdata); end
  endtask

  task automatic test_bypass();
    do_reset();
    cycle(0, 0, 0, 1, 5'd5, 32'h1234);
    n_vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234)
      begin n_err++; $display("FAIL bypass got we=%0b rd=%0d d=%h want 1/5/1234", rf_we, rf_rd, rf_wdata); end
    n_vec++; if (buf_cnt !== 2'd0) begin n_err++; $display("FAIL bypass_cnt got %0d want 0", buf_cnt); end
  endtask

  task automatic test_starvation();
    int stall_at = -1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, 5'd1, 32'h100 + i, (i == 0), 5'd7, 32'h77);
      if (pre_stall === 1'b1 && stall_at < 0) stall_at = i;
      n_vec++; if (pre_stall !== exp_stall)
        begin n_err++; $display("FAIL starve_stall[%0d] got %0b want %0b", i, pre_stall, exp_stall); end
      n_vec++; if (rf_we !== exp_we || (exp_we && (rf_rd !== exp_rd || rf_wdata !== exp_data)))
        begin n_err++; $display("FAIL starve_write[%0d] got %0b/%0d/%h want %0b/%0d/%h", i, rf_we, rf_rd, rf_wdata, exp_we, exp_rd, exp_data); end
    end
    n_vec++; if (stall_at != 5) begin n_err++; $display("FAIL starve_when got %0d want 5", stall_at); end
  endtask

  task automatic test_full();
    do_reset();
    cycle(1, 5'd2, 32'h2, 1, 5'd10, 32'hA);
    cycle(1, 5'd2, 32'h3, 1, 5'd11, 32'hB);
    n_vec++; if (buf_cnt !== 2'd2 || mdu_ready !== 1'b0)
      begin n_err++; $display("FAIL full got cnt=%0d rdy=%0b want 2/0", buf_cnt, mdu_ready); end
    cycle(1, 5'd2, 32'h4, 1, 5'd12, 32'hC);
    n_vec++; if (pre_ready !== 1'b0 || buf_cnt !== 2'd2)
      begin n_err++; $display("FAIL full_hold got rdy=%0b cnt=%0d want 0/2", pre_ready, buf_cnt); end
    cycle(0, 0, 0, 1, 5'd12, 32'hC);
    n_vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || buf_cnt !== 2'd1)
      begin n_err++; $display("FAIL full_pop got we=%0b rd=%0d cnt=%0d want 1/10/1", rf_we, rf_rd, buf_cnt); end
  endtask

  task automatic test_kill();
    do_reset();
    cycle(1, 5'd1, 32'h11, 1, 5'd9, 32'h55);
    cycle(1, 5'd9, 32'hAA, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_vec++; if (rf_we !== 1'b0 || buf_cnt !== 2'd0)
      begin n_err++; $display("FAIL kill_pop got we=%0b cnt=%0d want 0/0", rf_we, buf_cnt); end
    n_vec++; if (dut_rf[9] !== 32'hAA) begin n_err++; $display("FAIL kill_final got %h want aa", dut_rf[9]); end
  endtask

  task automatic test_x0();
    do_reset();
    cycle(1, 5'd0, 32'hF0, 1, 5'd0, 32'hF1);
    n_vec++; if (rf_we !== 1'b0 || buf_cnt !== 2'd0)
      begin n_err++; $display("FAIL x0 got we=%0b cnt=%0d want 0/0", rf_we, buf_cnt); end
  endtask

  task automatic test_random();
    bit          pw = 0, mv;
    logic [4:0]  prd = 0, mrd;
    logic [31:0] pd = 0, md;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!m_drain) begin
        pw = ($urandom_range(0, 3) != 0);
        prd = 5'($urandom_range(0, 7));
        pd = $urandom;
      end
      mv = ($urandom_range(0, 2) == 0);
      mrd = 5'($urandom_range(0, 7));
      md = $urandom;
      cycle(pw, prd, pd, mv, mrd, md);
      n_vec++; if (pre_stall !== exp_stall || pre_ready !== exp_ready)
        begin n_err++; $display("FAIL rand_ctl[%0d] got st=%0b rdy=%0b want %0b/%0b", i, pre_stall, pre_ready, exp_stall, exp_ready); end
      n_vec++; if (rf_we !== exp_we || (exp_we && (rf_rd !== exp_rd || rf_wdata !== exp_data)))
        begin n_err++; $display("FAIL rand_write[%0d] got %0b/%0d/%h want %0b/%0d/%h", i, rf_we, rf_rd, rf_wdata, exp_we, exp_rd, exp_data); end
      n_vec++; if (int'(buf_cnt) != exp_cnt)
        begin n_err++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, buf_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_starvation();
    test_full();
    test_kill();
    test_x0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
